// File: rtl/discrete_trigger_scheduler.sv
// Turns sound-latch request bits into per-channel discrete-circuit gate enables with
// minimum/maximum on-time, retrigger, post-release hold-off and a cap on concurrent voices.
module discrete_trigger_scheduler #(
  parameter int NUM_CH          = 4,
  parameter int MAX_ACTIVE      = 2,
  parameter int MIN_ON_SAMPLES  = 480,
  parameter int MAX_ON_SAMPLES  = 0,
  parameter int HOLDOFF_SAMPLES = 96,
  parameter int CNT_W           = 16,
  parameter int OUT_INVERT      = 0
) (
  input  logic                                   clk,
  input  logic                                   I_RSTn,
  input  logic                                   audio_clk_en,
  input  logic [NUM_CH-1:0]                      req,
  output logic [NUM_CH-1:0]                      en_out,
  output logic [$clog2(MAX_ACTIVE+1)-1:0]        active_count,
  output logic                                   overflow
);

  localparam int AC_W = $clog2(MAX_ACTIVE + 1);
  localparam logic INV = (OUT_INVERT != 0);
  localparam logic [CNT_W:0] MIN_L  = (CNT_W+1)'(MIN_ON_SAMPLES);
  localparam logic [CNT_W:0] MAX_L  = (CNT_W+1)'(MAX_ON_SAMPLES);
  localparam logic [CNT_W:0] HOLD_L = (CNT_W+1)'(HOLDOFF_SAMPLES);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD} state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] req_q, pend_q, pend_d, edge_w, eff_pend, grant, en_d;
  logic [AC_W-1:0]   ac_d;
  logic              ovf_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // An edge arriving on the same clk as a tick is served by that tick, never dropped.
  assign edge_w   = req & ~req_q;
  assign eff_pend = pend_q | edge_w;

  // Slots freed by releases on this tick only become usable on the next tick.
  always_comb begin
    int free;
    int n_granted;
    free      = MAX_ACTIVE - int'(active_count);
    n_granted = 0;
    grant     = '0;
    ovf_d     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q[i] == S_IDLE && eff_pend[i]) begin
        if (n_granted < free) begin
          grant[i]  = 1'b1;
          n_granted = n_granted + 1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [CNT_W:0] cnt_p1;
    logic           rel;
    int             n_act;
    cnt_p1 = '0;
    rel    = 1'b0;
    n_act  = 0;
    pend_d = eff_pend;
    en_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_p1     = {1'b0, cnt_q[i]} + 1'b1;
      rel        = 1'b0;
      if (audio_clk_en) begin
        case (state_q[i])
          S_IDLE: begin
            if (grant[i]) begin
              state_d[i] = S_ACTIVE;
              cnt_d[i]   = '0;
              pend_d[i]  = 1'b0;
            end
          end
          S_ACTIVE: begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            // Max-on release outranks retrigger; retrigger outranks min-on release.
            if (MAX_ON_SAMPLES != 0 && cnt_p1 == MAX_L) begin
              rel = 1'b1;
            end else if (eff_pend[i]) begin
              cnt_d[i]  = '0;
              pend_d[i] = 1'b0;
            end else if (!req[i] && cnt_p1 >= MIN_L) begin
              rel = 1'b1;
            end
            if (rel) begin
              state_d[i] = (HOLDOFF_SAMPLES == 0) ? S_IDLE : S_HOLD;
              cnt_d[i]   = '0;
            end
          end
          S_HOLD: begin
            cnt_d[i] = sat_inc(cnt_q[i]);
            if (cnt_p1 == HOLD_L) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = '0;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      en_d[i] = (state_d[i] == S_ACTIVE) ^ INV;
      if (state_d[i] == S_ACTIVE) n_act = n_act + 1;
    end
    ac_d = AC_W'(n_act);
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      req_q        <= '0;
      pend_q       <= '0;
      en_out       <= {NUM_CH{INV}};
      active_count <= '0;
      overflow     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      req_q        <= req;
      pend_q       <= pend_d;
      en_out       <= en_d;
      active_count <= ac_d;
      overflow     <= audio_clk_en & ovf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule
